// File: rtl/adc_clock_divider_prog.sv
// ---------------------------------------------------------------------------
// adc_clock_divider_prog
//
// Derives the ADC conversion clock from Clck_in. The half-period can be
// reloaded at runtime, and start/stop is clean. A new half-period only takes
// effect at a half-period boundary, so Clock_out never produces a runt pulse.
//
// Each level of Clock_out lasts half_act+1 cycles.
// The full period is therefore 2*(half_act+1) cycles.
//
// Ports
//   Clck_in        in   1      system clock, rising edge
//   reset_Clock_n  in   1      asynchronous reset, active-low
//   enable         in   1      1 = run, 0 = stop at the next low level
//   half_cfg       in   DIV_W  new half-period (cycles-1), sampled on cfg_load
//   cfg_load       in   1      single-cycle load strobe
//   Clock_out      out  1      divided clock, registered
//   rise_stb       out  1      high during the first cycle Clock_out reads 1
//   fall_stb       out  1      high during the first cycle Clock_out reads 0
//   running        out  1      FSM is not in IDLE
//   cfg_err        out  1      one-cycle pulse when a load is rejected
//
// Build option
//   ADC_DIV_STROBE_EN : when defined, rise_stb and fall_stb are generated.
//                       When undefined, both are tied 0 and the strobe
//                       flops do not exist.
//
// FSM states
//   state | meaning
//   IDLE  | stopped; counter held at 0, Clock_out low
//   RUN   | free-running divider
//   STOP  | enable dropped while high; finish the high level, then go IDLE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_clock_divider_prog #(
    parameter int DIV_W    = 12,
    parameter int DEF_HALF = 2499,
    parameter int MIN_HALF = 1
) (
    input  logic             Clck_in,
    input  logic             reset_Clock_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_cfg,
    input  logic             cfg_load,
    output logic             Clock_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_half_act;
    logic [DIV_W-1:0] r_half_pend;
    logic             r_pend_valid;
    logic             r_clk;
    logic             r_cfg_err;

    logic             w_cfg_ok;
    logic             w_cfg_bad;
    logic             w_term;
    logic             w_abort;

    assign w_cfg_ok  = cfg_load && (half_cfg >= DIV_W'(MIN_HALF));
    assign w_cfg_bad = cfg_load && (half_cfg <  DIV_W'(MIN_HALF));

    // A terminal count only exists while the divider is active.
    assign w_term    = (r_state != IDLE) && (r_cnt == r_half_act);

    // Stop during a low level: leave at once, with no further toggle.
    assign w_abort   = (r_state == RUN) && !enable && !r_clk;

    always_ff @(posedge Clck_in or negedge reset_Clock_n) begin
        if (!reset_Clock_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_half_act   <= DIV_W'(DEF_HALF);
            r_half_pend  <= '0;
            r_pend_valid <= 1'b0;
            r_clk        <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_bad;

            // Half-period update.
            // A load is applied directly in IDLE, or when it lands on a
            // terminal count. Otherwise it waits in half_pend until the
            // next boundary.
            if (w_cfg_ok && ((r_state == IDLE) || w_term)) begin
                r_half_act   <= half_cfg;
                r_pend_valid <= 1'b0;
            end else if (w_cfg_ok) begin
                r_half_pend  <= half_cfg;
                r_pend_valid <= 1'b1;
            end else if (w_term && r_pend_valid) begin
                r_half_act   <= r_half_pend;
                r_pend_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        if (w_term) begin
                            r_cnt <= '0;
                            r_clk <= ~r_clk;
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                        // Only reached with Clock_out high. If this is the
                        // terminal count, the fall happens now and we are done.
                        if (!enable) begin
                            r_state <= w_term ? IDLE : STOP;
                        end
                    end
                end
                STOP: begin
                    // Clock_out is always high here, so the terminal
                    // count is the falling edge.
                    if (w_term) begin
                        r_cnt <= '0;
                        r_clk <= ~r_clk;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                    if (enable) begin
                        r_state <= RUN;
                    end else if (w_term) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_clk   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADC_DIV_STROBE_EN
    logic r_rise_stb;
    logic r_fall_stb;
    logic w_toggle;

    assign w_toggle = w_term && !w_abort;

    // Registered alongside r_clk, so each strobe lines up with the first
    // cycle of its new level.
    always_ff @(posedge Clck_in or negedge reset_Clock_n) begin
        if (!reset_Clock_n) begin
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else begin
            r_rise_stb <= w_toggle && !r_clk;
            r_fall_stb <= w_toggle &&  r_clk;
        end
    end

    assign rise_stb = r_rise_stb;
    assign fall_stb = r_fall_stb;
`else
    assign rise_stb = 1'b0;
    assign fall_stb = 1'b0;
`endif

    assign Clock_out = r_clk;
    assign running   = (r_state != IDLE);
    assign cfg_err   = r_cfg_err;

endmodule
